// File: rtl/lcd_timing_gen_if.sv
// Video-side bundle for lcd_timing_gen: window control, video RAM read port and display outputs.
interface lcd_timing_gen_if #(
  parameter int PIX_W = 16,
  parameter int AW    = 12
);
  logic [15:0]      win_x;
  logic [15:0]      win_y;
  logic [PIX_W-1:0] bg_color;
  logic [AW-1:0]    rd_addr;
  logic             rd_en;
  logic [PIX_W-1:0] rd_data;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [PIX_W-1:0] pixel;
  logic             frame_start;

  modport master (
    output win_x, win_y, bg_color, rd_data,
    input  rd_addr, rd_en, hsync, vsync, de, pixel, frame_start
  );

  modport slave (
    input  win_x, win_y, bg_color, rd_data,
    output rd_addr, rd_en, hsync, vsync, de, pixel, frame_start
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator with a scaled, frame-shadowed window fetched from video RAM.
module lcd_timing_gen #(
  parameter int H_ACTIVE     = 480,
  parameter int H_BACK       = 43,
  parameter int H_FRONT      = 8,
  parameter int H_PULSE      = 4,
  parameter int V_ACTIVE     = 272,
  parameter int V_BACK       = 12,
  parameter int V_FRONT      = 8,
  parameter int V_PULSE      = 4,
  parameter int WIN_W_LOG2   = 8,
  parameter int WIN_H_LOG2   = 8,
  parameter int SCALE_LOG2   = 2,
  parameter int PIX_W        = 16,
  parameter int RD_LATENCY   = 1,
  parameter int SYNC_ACT_LOW = 1
) (
  input logic             clk,
  input logic             rst,
  lcd_timing_gen_if.slave vid
);
  localparam int H_TOTAL = H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_BACK + V_ACTIVE + V_FRONT;
  localparam int PIPE    = RD_LATENCY + 2;
  localparam int AW      = (WIN_W_LOG2 - SCALE_LOG2) + (WIN_H_LOG2 - SCALE_LOG2);
  localparam bit ACT_LOW = (SYNC_ACT_LOW != 0);

  // Control bits are carried active-high through the pipe so reset (all 0) means "deasserted".
  typedef struct packed {
    logic fs;
    logic de;
    logic vs;
    logic hs;
  } ctl_t;

  logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [15:0] wx_q, wy_q;
  logic        first_q;
  logic        h_last, v_last, load_win;
  logic [15:0] x, y, wx, wy;
  logic        in_win;
  ctl_t        ctl_raw;

  logic                      rd_en_q;
  logic [AW-1:0]             rd_addr_q, rd_addr_d;
  ctl_t [PIPE:1]             ctl_pipe_q;
  logic [RD_LATENCY+1:1]     win_pipe_q;
  logic [PIX_W-1:0]          pixel_q;

  assign h_last   = (h_cnt_q == 16'(H_TOTAL - 1));
  assign v_last   = (v_cnt_q == 16'(V_TOTAL - 1));
  // Window origin is sampled once per frame, plus on the very first clock out of reset.
  assign load_win = first_q | (h_last & v_last);

  always_comb begin
    h_cnt_d = h_last ? 16'd0 : h_cnt_q + 16'd1;
    v_cnt_d = v_cnt_q;
    if (h_last) v_cnt_d = v_last ? 16'd0 : v_cnt_q + 16'd1;
  end

  assign x  = h_cnt_q - 16'(H_BACK);
  assign y  = v_cnt_q - 16'(V_BACK);
  assign wx = x - wx_q;
  assign wy = y - wy_q;

  always_comb begin
    ctl_raw    = '0;
    ctl_raw.hs = (h_cnt_q < 16'(H_PULSE));
    ctl_raw.vs = (v_cnt_q < 16'(V_PULSE));
    ctl_raw.fs = (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);
    ctl_raw.de = (h_cnt_q >= 16'(H_BACK)) && (h_cnt_q < 16'(H_BACK + H_ACTIVE)) &&
                 (v_cnt_q >= 16'(V_BACK)) && (v_cnt_q < 16'(V_BACK + V_ACTIVE));
    // Offsets below the origin wrap to large values and fall out of range; de clips the right edge.
    in_win     = ctl_raw.de && ((wx >> WIN_W_LOG2) == 16'd0) && ((wy >> WIN_H_LOG2) == 16'd0);
    rd_addr_d  = rd_addr_q;
    if (in_win)
      rd_addr_d = (AW'(wy >> SCALE_LOG2) << (WIN_W_LOG2 - SCALE_LOG2)) | AW'(wx >> SCALE_LOG2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      wx_q       <= '0;
      wy_q       <= '0;
      first_q    <= 1'b1;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      ctl_pipe_q <= '0;
      win_pipe_q <= '0;
      pixel_q    <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      first_q       <= 1'b0;
      if (load_win) begin
        wx_q <= vid.win_x;
        wy_q <= vid.win_y;
      end
      rd_en_q       <= in_win;
      rd_addr_q     <= rd_addr_d;
      ctl_pipe_q[1] <= ctl_raw;
      for (int i = 2; i <= PIPE; i++) ctl_pipe_q[i] <= ctl_pipe_q[i-1];
      win_pipe_q[1] <= in_win;
      for (int i = 2; i <= RD_LATENCY + 1; i++) win_pipe_q[i] <= win_pipe_q[i-1];
      // Stage RD_LATENCY+1 lines up with the cycle rd_data answers the stage-1 address.
      if (ctl_pipe_q[RD_LATENCY+1].de)
        pixel_q <= win_pipe_q[RD_LATENCY+1] ? vid.rd_data : vid.bg_color;
      else
        pixel_q <= '0;
    end
  end

  assign vid.rd_en       = rd_en_q;
  assign vid.rd_addr     = rd_addr_q;
  assign vid.hsync       = ctl_pipe_q[PIPE].hs ^ ACT_LOW;
  assign vid.vsync       = ctl_pipe_q[PIPE].vs ^ ACT_LOW;
  assign vid.de          = ctl_pipe_q[PIPE].de;
  assign vid.frame_start = ctl_pipe_q[PIPE].fs;
  assign vid.pixel       = pixel_q;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen on a small raster: three instances (latency 1, latency 2, active-high sync).
module tb_lcd_timing_gen;
  localparam int HT = 13, VT = 7, FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] win_x, win_y;
  logic [7:0]  bg;
  logic [7:0]  rb1;

  always #5 clk = ~clk;

  lcd_timing_gen_if #(.PIX_W(8), .AW(1)) ifa ();
  lcd_timing_gen_if #(.PIX_W(8), .AW(1)) ifb ();
  lcd_timing_gen_if #(.PIX_W(8), .AW(1)) ifc ();

  assign ifa.win_x = win_x;  assign ifa.win_y = win_y;  assign ifa.bg_color = bg;
  assign ifb.win_x = win_x;  assign ifb.win_y = win_y;  assign ifb.bg_color = bg;
  assign ifc.win_x = win_x;  assign ifc.win_y = win_y;  assign ifc.bg_color = bg;

  // Video RAM models: data equals address, returned after the instance's read latency.
  always @(posedge clk) ifa.rd_data <= {7'd0, ifa.rd_addr};
  always @(posedge clk) ifc.rd_data <= {7'd0, ifc.rd_addr};
  always @(posedge clk) begin
    rb1         <= {7'd0, ifb.rd_addr};
    ifb.rd_data <= rb1;
  end

  lcd_timing_gen #(.H_ACTIVE(8), .H_BACK(3), .H_FRONT(2), .H_PULSE(1), .V_ACTIVE(4), .V_BACK(2),
    .V_FRONT(1), .V_PULSE(1), .WIN_W_LOG2(2), .WIN_H_LOG2(1), .SCALE_LOG2(1), .PIX_W(8),
    .RD_LATENCY(1), .SYNC_ACT_LOW(1)) dut_a (.clk(clk), .rst(rst), .vid(ifa.slave));
  lcd_timing_gen #(.H_ACTIVE(8), .H_BACK(3), .H_FRONT(2), .H_PULSE(1), .V_ACTIVE(4), .V_BACK(2),
    .V_FRONT(1), .V_PULSE(1), .WIN_W_LOG2(2), .WIN_H_LOG2(1), .SCALE_LOG2(1), .PIX_W(8),
    .RD_LATENCY(2), .SYNC_ACT_LOW(1)) dut_b (.clk(clk), .rst(rst), .vid(ifb.slave));
  lcd_timing_gen #(.H_ACTIVE(8), .H_BACK(3), .H_FRONT(2), .H_PULSE(1), .V_ACTIVE(4), .V_BACK(2),
    .V_FRONT(1), .V_PULSE(1), .WIN_W_LOG2(2), .WIN_H_LOG2(1), .SCALE_LOG2(1), .PIX_W(8),
    .RD_LATENCY(1), .SYNC_ACT_LOW(0)) dut_c (.clk(clk), .rst(rst), .vid(ifc.slave));

  typedef struct {
    int         f;
    int         x;
    int         y;
    bit         is_rd;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    bit         hs, vs, de, fs;
    logic [7:0] pix;
  } exp_t;

  vec_t        tbl [16];
  logic [15:0] hx [0:1023];
  logic [15:0] hy [0:1023];
  logic [7:0]  hb [0:1023];
  int          t, phase, n_chk, n_err;
  int          cnt_de, cnt_hs, cnt_vs, cnt_fs;
  bit          e_en;
  logic        e_addr;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%h want=%h", nm, t, act, exp);
    end
  endtask

  // Window membership of raster position s, using the origin latched for that frame.
  function automatic bit inwin(input int s, output logic [7:0] a);
    int h, v, f, src;
    logic [15:0] wx, wy;
    h = s % HT;  v = (s / HT) % VT;  f = s / FR;
    src = (f == 0) ? 0 : FR * f - 1;
    a = 8'd0;
    if (!(h >= 3 && h < 11 && v >= 2 && v < 6)) return 1'b0;
    wx = 16'(h - 3) - hx[src];
    wy = 16'(v - 2) - hy[src];
    if (wx < 16'd4 && wy < 16'd2) begin
      a = 8'((wy / 2) * 2 + wx / 2);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic exp_t model(input int tt, input int lat);
    exp_t e;
    int s, h, v;
    logic [7:0] a;
    e = '{default: 0};
    s = tt - (lat + 2);
    if (s < 0) return e;
    h = s % HT;  v = (s / HT) % VT;
    e.hs = (h < 1);
    e.vs = (v < 1);
    e.fs = (h == 0 && v == 0);
    e.de = (h >= 3 && h < 11 && v >= 2 && v < 6);
    if (e.de) e.pix = inwin(s, a) ? a : hb[tt-1];
    return e;
  endfunction

  task automatic chk_reset(input string nm);
    chk({nm, "_a_hs"}, 16'(ifa.hsync), 16'd1);  chk({nm, "_a_vs"}, 16'(ifa.vsync), 16'd1);
    chk({nm, "_a_de"}, 16'(ifa.de), 16'd0);     chk({nm, "_a_pix"}, 16'(ifa.pixel), 16'd0);
    chk({nm, "_a_fs"}, 16'(ifa.frame_start), 16'd0);
    chk({nm, "_a_rd"}, {14'd0, ifa.rd_en, ifa.rd_addr}, 16'd0);
    chk({nm, "_b_hs"}, 16'(ifb.hsync), 16'd1);  chk({nm, "_b_de"}, 16'(ifb.de), 16'd0);
    chk({nm, "_c_hs"}, 16'(ifc.hsync), 16'd0);  chk({nm, "_c_vs"}, 16'(ifc.vsync), 16'd0);
  endtask

  task automatic check_cycle();
    exp_t ea, eb;
    logic [7:0] a;
    int tgt;
    hx[t] = win_x;  hy[t] = win_y;  hb[t] = bg;
    if (t >= 1) begin
      if (inwin(t - 1, a)) begin
        e_en = 1'b1;  e_addr = a[0];
      end else e_en = 1'b0;
    end
    ea = model(t, 1);
    eb = model(t, 2);
    chk("a_hsync", 16'(ifa.hsync), 16'(!ea.hs));  chk("a_vsync", 16'(ifa.vsync), 16'(!ea.vs));
    chk("a_de", 16'(ifa.de), 16'(ea.de));         chk("a_fs", 16'(ifa.frame_start), 16'(ea.fs));
    chk("a_pixel", 16'(ifa.pixel), 16'(ea.pix));
    chk("a_rd", {14'd0, ifa.rd_en, ifa.rd_addr}, {14'd0, e_en, e_addr});
    chk("b_hsync", 16'(ifb.hsync), 16'(!eb.hs));  chk("b_vsync", 16'(ifb.vsync), 16'(!eb.vs));
    chk("b_de", 16'(ifb.de), 16'(eb.de));         chk("b_fs", 16'(ifb.frame_start), 16'(eb.fs));
    chk("b_pixel", 16'(ifb.pixel), 16'(eb.pix));
    chk("b_rd", {14'd0, ifb.rd_en, ifb.rd_addr}, {14'd0, e_en, e_addr});
    chk("c_hsync", 16'(ifc.hsync), 16'(ea.hs));   chk("c_vsync", 16'(ifc.vsync), 16'(ea.vs));
    if (phase == 1) begin
      for (int i = 0; i < 16; i++) begin
        tgt = tbl[i].f * FR + (tbl[i].y + 2) * HT + tbl[i].x + 3 + (tbl[i].is_rd ? 1 : 3);
        if (t == tgt) begin
          if (tbl[i].is_rd) chk($sformatf("tbl%0d_rd", i), {14'd0, ifa.rd_en, ifa.rd_addr}, 16'(tbl[i].exp));
          else chk($sformatf("tbl%0d_pix", i), {7'd0, ifa.de, ifa.pixel}, {7'd1, tbl[i].exp});
        end
      end
      if (t >= 3 && t < 3 + 2 * FR) begin
        cnt_de += int'(ifa.de);  cnt_hs += int'(!ifa.hsync);
        cnt_vs += int'(!ifa.vsync);  cnt_fs += int'(ifa.frame_start);
      end
    end
  endtask

  task automatic drive();
    if (phase == 2 || t >= 2 * FR) begin
      bg = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        win_x = 16'($urandom_range(0, 12));
        win_y = 16'($urandom_range(0, 6));
      end
    end
    if (phase == 1 && t == 40)  win_x = 16'd5;
    if (phase == 1 && t == 272) win_x = 16'd1;
    if (phase == 1 && t == 273) win_x = 16'd7;
  endtask

  task automatic run(input int ncyc);
    while (t < ncyc) begin
      @(negedge clk);
      check_cycle();
      t++;
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  initial begin
    tbl[0]  = '{0, 1, 1, 1'b0, 8'hA5};  tbl[1]  = '{0, 2, 1, 1'b0, 8'h00};
    tbl[2]  = '{0, 3, 1, 1'b0, 8'h00};  tbl[3]  = '{0, 4, 1, 1'b0, 8'h01};
    tbl[4]  = '{0, 5, 1, 1'b0, 8'h01};  tbl[5]  = '{0, 6, 1, 1'b0, 8'hA5};
    tbl[6]  = '{0, 2, 2, 1'b0, 8'h00};  tbl[7]  = '{0, 5, 2, 1'b0, 8'h01};
    tbl[8]  = '{0, 3, 0, 1'b0, 8'hA5};  tbl[9]  = '{0, 3, 3, 1'b0, 8'hA5};
    tbl[10] = '{1, 4, 1, 1'b0, 8'hA5};  tbl[11] = '{1, 5, 1, 1'b0, 8'h00};
    tbl[12] = '{1, 6, 1, 1'b0, 8'h00};  tbl[13] = '{1, 7, 2, 1'b0, 8'h01};
    tbl[14] = '{1, 7, 1, 1'b1, 8'h03};  tbl[15] = '{1, 8, 1, 1'b1, 8'h01};
    n_chk = 0;  n_err = 0;  t = 0;  phase = 0;
    cnt_de = 0;  cnt_hs = 0;  cnt_vs = 0;  cnt_fs = 0;
    win_x = 16'd2;  win_y = 16'd1;  bg = 8'hA5;
    e_en = 1'b0;  e_addr = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset("init");
    @(posedge clk);
    #2 rst = 1'b1;
    phase = 1;
    run(500);

    // Reset lands mid active line; outputs must drop without waiting for a clock.
    #1 rst = 1'b0;
    #1 chk_reset("midrst");
    repeat (2) @(posedge clk);
    #1 win_x = 16'($urandom_range(0, 12));
    win_y = 16'($urandom_range(0, 6));
    @(posedge clk);
    #2 rst = 1'b1;
    t = 0;  phase = 2;  e_en = 1'b0;  e_addr = 1'b0;
    run(200);

    chk("cnt_de", 16'(cnt_de), 16'd64);
    chk("cnt_hsync", 16'(cnt_hs), 16'd14);
    chk("cnt_vsync", 16'(cnt_vs), 16'd26);
    chk("cnt_fs", 16'(cnt_fs), 16'd2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
